// File: rtl/btn_cond_if.sv
`default_nettype none
// ============================================================================
//  Module      : btn_cond_if
//  Description : Bundles the button-conditioner signals. The master modport
//                drives raw buttons and the frame strobe; the slave modport
//                (the conditioner) returns debounced levels, serve strobes
//                and per-frame paddle directions.
//  Signals     : btn_in[5:0]   raw buttons {p2_srv,p2_dn,p2_up,p1_srv,p1_dn,p1_up}
//                frame_tick    one-cycle strobe per frame
//                btn_lvl[5:0]  debounced levels, same order as btn_in
//                srv_pulse[1:0]{p2,p1} one-cycle serve press strobes
//                p1_dir[1:0]   signed paddle-1 direction, held per frame
//                p2_dir[1:0]   signed paddle-2 direction, held per frame
//  Revision    : 1.0 - initial release
// ============================================================================
interface btn_cond_if;
  logic [5:0] btn_in;
  logic       frame_tick;
  logic [5:0] btn_lvl;
  logic [1:0] srv_pulse;
  logic [1:0] p1_dir;
  logic [1:0] p2_dir;

  modport master (
    output btn_in,
    output frame_tick,
    input  btn_lvl,
    input  srv_pulse,
    input  p1_dir,
    input  p2_dir
  );

  modport slave (
    input  btn_in,
    input  frame_tick,
    output btn_lvl,
    output srv_pulse,
    output p1_dir,
    output p2_dir
  );
endinterface
`default_nettype wire

// File: rtl/btn_cond.sv
`default_nettype none
// ============================================================================
//  Module      : btn_cond
//  Description : Button conditioner. Each raw button is synchronised with two
//                flops, then debounced by a per-bit counter that must see the
//                new value for DEB_MAX consecutive cycles before the level is
//                accepted. Serve buttons yield a one-cycle rising-edge strobe;
//                paddle directions are sampled once per frame.
//  Ports       : clk      system (pixel) clock
//                rst_n    asynchronous active-low reset
//                bus      btn_cond_if.slave (btn_in, frame_tick in;
//                         btn_lvl, srv_pulse, p1_dir, p2_dir out)
//  Parameters  : DEB_MAX  stable cycles required to accept a change (1..65535)
//                CNT_W    debounce counter width, must hold DEB_MAX-1
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_cond #(
  parameter int DEB_MAX = 50000,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  btn_cond_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(DEB_MAX - 1);

  logic [5:0] r_sync1;
  logic [5:0] r_sync2;
  logic [5:0] w_lvl;
  logic [1:0] r_srv_prev;
  logic [1:0] r_p1_dir;
  logic [1:0] r_p2_dir;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // Independent debouncer per bit. The counter only runs while the
  // synchronised input disagrees with the accepted level, so any return to
  // agreement restarts the count from zero.
  for (genvar i = 0; i < 6; i++) begin : g_bit
    logic [CNT_W-1:0] r_cnt;
    logic             r_state;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_state <= 1'b0;
      end else if (r_sync2[i] == r_state) begin
        r_cnt   <= '0;
      end else if (r_cnt >= c_last) begin
        r_state <= r_sync2[i];
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end

    assign w_lvl[i] = r_state;
  end

  // Previous level of the two serve bits, for rising-edge detection.
  // The strobe is combinational so it coincides with the level rising.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_srv_prev <= '0;
    end else begin
      r_srv_prev <= {w_lvl[5], w_lvl[2]};
    end
  end

  // Direction = up - dn in 2-bit two's complement: {dn & ~up, up ^ dn}.
  // Loaded on every frame_tick cycle from the already-registered levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_dir <= '0;
      r_p2_dir <= '0;
    end else if (bus.frame_tick) begin
      r_p1_dir <= {w_lvl[1] & ~w_lvl[0], w_lvl[1] ^ w_lvl[0]};
      r_p2_dir <= {w_lvl[4] & ~w_lvl[3], w_lvl[4] ^ w_lvl[3]};
    end
  end

  assign bus.btn_lvl   = w_lvl;
  assign bus.srv_pulse = {w_lvl[5] & ~r_srv_prev[1], w_lvl[2] & ~r_srv_prev[0]};
  assign bus.p1_dir    = r_p1_dir;
  assign bus.p2_dir    = r_p2_dir;

endmodule
`default_nettype wire

// File: tb/tb_btn_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_cond
//  Description : Self-checking bench for btn_cond with DEB_MAX = 4. Stimulus
//                segments {rst_n, btn_in, frame_tick, cycles, expected
//                outputs} are applied one cycle at a time; each cycle's
//                expected outputs go into a scoreboard queue and are compared
//                just after the following rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_cond;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  btn_cond_if bus ();

  btn_cond #(
    .DEB_MAX (4),
    .CNT_W   (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rst_n;
    logic [5:0] btn;
    logic       ft;
    int         cyc;
    logic [5:0] lvl;
    logic [1:0] srv;
    logic [1:0] p1;
    logic [1:0] p2;
  } vec_t;

  typedef struct {
    logic [11:0] exp;
    int          seg;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t        m_e;
  logic [11:0] m_act;

  function automatic vec_t v(logic r, logic [5:0] b, logic f, int c,
                             logic [5:0] l, logic [1:0] s,
                             logic [1:0] d1, logic [1:0] d2);
    vec_t t;
    t.rst_n = r; t.btn = b; t.ft = f; t.cyc = c;
    t.lvl = l; t.srv = s; t.p1 = d1; t.p2 = d2;
    return t;
  endfunction

  // Monitor: compare one scoreboard entry just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      m_e   = sb.pop_front();
      m_act = {bus.btn_lvl, bus.srv_pulse, bus.p1_dir, bus.p2_dir};
      n_cmp++;
      if (m_act !== m_e.exp) begin
        n_err++;
        $display("FAIL seg%0d t=%0t: lvl/srv/p1/p2 got %h/%b/%b/%b want %h/%b/%b/%b",
                 m_e.seg, $time, m_act[11:6], m_act[5:4], m_act[3:2], m_act[1:0],
                 m_e.exp[11:6], m_e.exp[5:4], m_e.exp[3:2], m_e.exp[1:0]);
      end
    end
  end

  initial begin
    exp_t e;
    rst_n          = 1'b0;
    bus.btn_in     = '0;
    bus.frame_tick = 1'b0;

    // Reset state
    vecs.push_back(v(0, 6'h00, 0, 3, 6'h00, 2'b00, 2'b00, 2'b00));
    // Press and hold p1_up: level appears on the 6th edge; then release
    vecs.push_back(v(1, 6'h01, 0, 5, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h01, 0, 1, 6'h01, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h01, 0, 3, 6'h01, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 5, 6'h01, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 1, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 2, 6'h00, 2'b00, 2'b00, 2'b00));
    // 3-cycle glitch on p2_up: rejected
    vecs.push_back(v(1, 6'h08, 0, 3, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 8, 6'h00, 2'b00, 2'b00, 2'b00));
    // 4-cycle pulse (exactly DEB_MAX): accepted as a 4-cycle level pulse
    vecs.push_back(v(1, 6'h08, 0, 4, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 1, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 4, 6'h08, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 3, 6'h00, 2'b00, 2'b00, 2'b00));
    // p1 serve held 20 cycles: one pulse; release gives none; re-press pulses again
    vecs.push_back(v(1, 6'h04, 0, 5,  6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h04, 0, 1,  6'h04, 2'b01, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h04, 0, 14, 6'h04, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 5,  6'h04, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 1,  6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 2,  6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h04, 0, 5,  6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h04, 0, 1,  6'h04, 2'b01, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h04, 0, 3,  6'h04, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 5,  6'h04, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 3,  6'h00, 2'b00, 2'b00, 2'b00));
    // Directions: p1_up, p2_up+p2_dn, then frame tick
    vecs.push_back(v(1, 6'h19, 0, 5, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h19, 0, 3, 6'h19, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h19, 1, 1, 6'h19, 2'b00, 2'b01, 2'b00));
    // Release p1_up without a frame tick: direction holds until next tick
    vecs.push_back(v(1, 6'h18, 0, 5, 6'h19, 2'b00, 2'b01, 2'b00));
    vecs.push_back(v(1, 6'h18, 0, 1, 6'h18, 2'b00, 2'b01, 2'b00));
    vecs.push_back(v(1, 6'h18, 0, 3, 6'h18, 2'b00, 2'b01, 2'b00));
    vecs.push_back(v(1, 6'h18, 1, 1, 6'h18, 2'b00, 2'b00, 2'b00));
    // Level changes on the same edge as a tick: tick sees old levels,
    // then a held tick reloads p1=dn only (11), p2=dn only (11)
    vecs.push_back(v(1, 6'h12, 0, 5, 6'h18, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h12, 1, 1, 6'h12, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h12, 1, 2, 6'h12, 2'b00, 2'b11, 2'b11));
    vecs.push_back(v(1, 6'h12, 0, 3, 6'h12, 2'b00, 2'b11, 2'b11));
    vecs.push_back(v(1, 6'h00, 0, 5, 6'h12, 2'b00, 2'b11, 2'b11));
    vecs.push_back(v(1, 6'h00, 0, 1, 6'h00, 2'b00, 2'b11, 2'b11));
    vecs.push_back(v(1, 6'h00, 1, 1, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 2, 6'h00, 2'b00, 2'b00, 2'b00));
    // Reset mid-count on p2_dn discards the partial count
    vecs.push_back(v(1, 6'h10, 0, 3, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(0, 6'h10, 0, 1, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h10, 0, 5, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h10, 0, 1, 6'h10, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h10, 0, 2, 6'h10, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 5, 6'h10, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 1, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 2, 6'h00, 2'b00, 2'b00, 2'b00));
    // p2 serve held through reset release: one pulse once debounced
    vecs.push_back(v(0, 6'h20, 0, 2, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h20, 0, 5, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h20, 0, 1, 6'h20, 2'b10, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h20, 0, 3, 6'h20, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 5, 6'h20, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 3, 6'h00, 2'b00, 2'b00, 2'b00));
    // All six bits change together
    vecs.push_back(v(1, 6'h3F, 0, 5, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h3F, 0, 1, 6'h3F, 2'b11, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h3F, 0, 3, 6'h3F, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h3F, 1, 1, 6'h3F, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 5, 6'h3F, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 1, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h00, 0, 2, 6'h00, 2'b00, 2'b00, 2'b00));
    // Both up only -> 01/01, then reset clears levels and directions
    vecs.push_back(v(1, 6'h09, 0, 5, 6'h00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h09, 0, 1, 6'h09, 2'b00, 2'b00, 2'b00));
    vecs.push_back(v(1, 6'h09, 1, 1, 6'h09, 2'b00, 2'b01, 2'b01));
    vecs.push_back(v(1, 6'h09, 0, 2, 6'h09, 2'b00, 2'b01, 2'b01));
    vecs.push_back(v(0, 6'h09, 0, 1, 6'h00, 2'b00, 2'b00, 2'b00));

    // Driver: inputs change on the falling edge, expectation queued for
    // the next rising edge.
    for (int s = 0; s < vecs.size(); s++) begin
      for (int c = 0; c < vecs[s].cyc; c++) begin
        @(negedge clk);
        rst_n          = vecs[s].rst_n;
        bus.btn_in     = vecs[s].btn;
        bus.frame_tick = vecs[s].ft;
        e.exp = {vecs[s].lvl, vecs[s].srv, vecs[s].p1, vecs[s].p2};
        e.seg = s;
        sb.push_back(e);
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btn_cond.md
BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 The block SHALL have parameter DEB_MAX, default 50000, meaning consecutive stable cycles required to accept a button change (legal range 1..65535).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning debounce counter width (must hold DEB_MAX-1).
REQ-003 The block SHALL have port clk, input, 1, system clock (pixel clock).
REQ-004 The block SHALL have port rst_n, input, 1, reset; one clock, asynchronous active-low reset.
REQ-005 The block SHALL have port btn_in, input, 6, raw asynchronous buttons {p2_srv, p2_dn, p2_up, p1_srv, p1_dn, p1_up}.
REQ-006 The block SHALL have port frame_tick, input, 1, single-cycle strobe once per frame (vsync falling edge).
REQ-007 The block SHALL have port btn_lvl, output, 6, debounced button levels, same bit order as btn_in.
REQ-008 The block SHALL have port srv_pulse, output, 2, {p2, p1} serve press strobes.
REQ-009 The block SHALL have port p1_dir, output, 2, signed paddle-1 direction latched per frame.
REQ-010 The block SHALL have port p2_dir, output, 2, signed paddle-2 direction latched per frame.

Function
REQ-011 Each btn_in bit SHALL pass through a 2-flop synchronizer (sync2) before any other use.
REQ-012 Each bit SHALL own an independent CNT_W-bit counter and a debounced state bit driving btn_lvl.
REQ-013 When sync2 equals state, the counter SHALL clear to 0 on that edge.
REQ-014 When sync2 differs from state and counter < DEB_MAX-1, the counter SHALL increment by 1.
REQ-015 When sync2 differs from state and counter == DEB_MAX-1, state SHALL take sync2 and the counter SHALL clear.
REQ-016 Latency: an input change held stable SHALL appear on btn_lvl exactly DEB_MAX+2 clock edges after the first edge that samples it.
REQ-017 A glitch shorter than DEB_MAX sync2 cycles SHALL never change btn_lvl; any return to equality restarts the count from 0.
REQ-018 srv_pulse[i] SHALL be high for exactly one cycle, the first cycle in which the corresponding serve bit of btn_lvl is 1 (state & ~registered previous state).
REQ-019 A held serve button SHALL produce no further pulses until it is released (debounced) and pressed again.
REQ-020 Falling serve edges SHALL produce no pulse.
REQ-021 On a frame_tick cycle, pN_dir SHALL load up - dn from btn_lvl as 2-bit two's complement: up only = 2'b01, dn only = 2'b11, both or neither = 2'b00.
REQ-022 Outside frame_tick cycles pN_dir SHALL hold its value; direction is therefore constant for a whole frame.
REQ-023 pN_dir SHALL sample btn_lvl as registered before the frame_tick edge (a btn_lvl change on the same edge takes effect at the next frame_tick).
REQ-024 frame_tick held high for multiple cycles SHALL reload pN_dir every such cycle (no internal edge detection).
REQ-025 All bits SHALL be processed in parallel; simultaneous changes on any bits SHALL be handled independently with identical latency.

Reset
REQ-026 While rst_n is low, the sync flops, counters, state, previous-state registers, btn_lvl, srv_pulse, p1_dir and p2_dir SHALL all be 0.
REQ-027 rst_n asserted mid-count SHALL discard the partial count; after release a still-pressed button SHALL need the full DEB_MAX+2 edges to appear.
REQ-028 A serve button already held at reset release SHALL produce one srv_pulse once it is debounced.

Verification (DEB_MAX=4)
REQ-029 Press btn_in[0] and hold -> btn_lvl[0] rises exactly 6 edges later; all other outputs stay 0.
REQ-030 Pulse btn_in[3] high for 3 cycles then low -> btn_lvl[3] stays 0 and srv_pulse stays 2'b00.
REQ-031 Hold btn_in[2] (p1_srv) for 20 cycles -> srv_pulse = 2'b01 for exactly one cycle, coincident with btn_lvl[2] rising; release and re-press -> a second single pulse.
REQ-032 Debounced p1_up=1, p1_dn=0, p2_up=1, p2_dn=1, then frame_tick -> p1_dir = 2'b01 and p2_dir = 2'b00; release p1_up and debounce without frame_tick -> p1_dir stays 2'b01 until the next frame_tick, then 2'b00.
REQ-033 Hold btn_in[4] for 3 edges, assert rst_n low for 1 cycle, release and keep holding -> btn_lvl[4] rises 6 edges after release, not earlier.
REQ-034 Change all 6 bits on the same edge -> all btn_lvl bits update on the same edge 6 edges later, and srv_pulse = 2'b11 for one cycle.
